// File: rtl/pc_run_monitor_pkg.sv
// Shared types and constants for the run-control monitor.
package pc_run_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_SIG     = 2'd0,
        CAUSE_HALT    = 2'd1,
        CAUSE_STALL   = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_e;

    localparam logic [31:0] DEFAULT_PASS_CODE = 32'h0000_0001;

endpackage

// File: rtl/pc_run_monitor_sat_counter.sv
// Saturating up-counter; o_nxt exposes the value being written this edge so
// the owner can act on the updated count without waiting a cycle.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_nxt
);
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_base;

    // clr and inc together load 1
    always_comb begin
        w_base = i_clr ? '0 : r_cnt;
        o_nxt  = (i_inc && !(&w_base)) ? w_base + W'(1) : w_base;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= o_nxt;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pc_run_monitor.sv
// Watches core PC / retire strobe / signature port and latches a sticky
// pass/fail verdict with its cause: SIG > HALT > STALL > TIMEOUT.
module pc_run_monitor
    import pc_run_monitor_pkg::*;
#(
    parameter int          PC_W        = 32,
    parameter int          CNT_W       = 32,
    parameter int          MAX_CYCLES  = 8000,
    parameter int          HALT_REPEAT = 4,
    parameter int          STALL_LIMIT = 64,
    parameter logic [31:0] PASS_CODE   = DEFAULT_PASS_CODE
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_insn_vld,
    input  logic             i_sig_vld,
    input  logic [31:0]      i_sig_data,
    output logic [2:0]       o_state,
    output logic             o_done,
    output logic             o_pass,
    output logic [1:0]       o_cause,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_insn_cnt,
    output logic [PC_W-1:0]  o_halt_pc,
    output logic [31:0]      o_sig
);
    state_e            r_state;
    cause_e            r_cause;
    logic              r_done, r_pass;
    logic [PC_W-1:0]   r_last_pc, r_halt_pc;
    logic [31:0]       r_sig;

    logic              w_run_en, w_same_pc;
    logic [CNT_W-1:0]  w_cyc_nxt, w_insn_nxt, w_stall_cnt, w_stall_nxt, w_rep_cnt, w_rep_nxt;
    logic              w_sig, w_halt, w_stall, w_tmo, w_term, w_pass;
    cause_e            w_cause;
    logic              w_unused;

    assign w_run_en  = (r_state == ST_RUN) && i_enable;
    assign w_same_pc = (i_pc == r_last_pc);

    sat_counter #(.W(CNT_W)) u_cyc (
        .i_clk(i_clk), .i_rst(i_reset), .i_clr(1'b0), .i_inc(w_run_en),
        .o_cnt(o_cycle_cnt), .o_nxt(w_cyc_nxt));

    sat_counter #(.W(CNT_W)) u_insn (
        .i_clk(i_clk), .i_rst(i_reset), .i_clr(1'b0), .i_inc(w_run_en && i_insn_vld),
        .o_cnt(o_insn_cnt), .o_nxt(w_insn_nxt));

    sat_counter #(.W(CNT_W)) u_stall (
        .i_clk(i_clk), .i_rst(i_reset),
        .i_clr(w_run_en && i_insn_vld), .i_inc(w_run_en && !i_insn_vld),
        .o_cnt(w_stall_cnt), .o_nxt(w_stall_nxt));

    // a retirement at a new PC restarts the run at 1
    sat_counter #(.W(CNT_W)) u_rep (
        .i_clk(i_clk), .i_rst(i_reset),
        .i_clr(w_run_en && i_insn_vld && !w_same_pc), .i_inc(w_run_en && i_insn_vld),
        .o_cnt(w_rep_cnt), .o_nxt(w_rep_nxt));

    assign w_unused = ^{w_insn_nxt, w_stall_cnt, w_rep_cnt};

    assign w_sig   = w_run_en && i_sig_vld;
    assign w_halt  = w_run_en && i_insn_vld && (w_rep_nxt >= CNT_W'(HALT_REPEAT));
    assign w_stall = w_run_en && !i_insn_vld && (w_stall_nxt >= CNT_W'(STALL_LIMIT));
    assign w_tmo   = w_run_en && (w_cyc_nxt >= CNT_W'(MAX_CYCLES));

    always_comb begin
        w_term  = 1'b1;
        w_pass  = 1'b0;
        w_cause = CAUSE_SIG;
        if (w_sig) begin
            w_pass = (i_sig_data == PASS_CODE);
        end else if (w_halt) begin
            w_cause = CAUSE_HALT;
            w_pass  = 1'b1;
        end else if (w_stall) begin
            w_cause = CAUSE_STALL;
        end else if (w_tmo) begin
            w_cause = CAUSE_TIMEOUT;
        end else begin
            w_term = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cause   <= CAUSE_SIG;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_last_pc <= '0;
            r_halt_pc <= '0;
            r_sig     <= '0;
        end else begin
            if (w_run_en && i_insn_vld) r_last_pc <= i_pc;
            case (r_state)
                ST_IDLE: if (i_enable) r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_term) begin
                        r_state   <= w_pass ? ST_PASS : ST_FAIL;
                        r_done    <= 1'b1;
                        r_pass    <= w_pass;
                        r_cause   <= w_cause;
                        r_halt_pc <= i_pc;
                    end
                    if (w_sig) r_sig <= i_sig_data;
                end
                default: ;
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_done    = r_done;
    assign o_pass    = r_pass;
    assign o_cause   = r_cause;
    assign o_halt_pc = r_halt_pc;
    assign o_sig     = r_sig;
endmodule

// File: tb/tb_pc_run_monitor.sv
// Bench for pc_run_monitor: scenario table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_pc_run_monitor;
    localparam int HR = 4;
    localparam int SL = 64;
    localparam int MC = 8000;

    logic        i_clk = 1'b0;
    logic        i_reset, i_enable, i_insn_vld, i_sig_vld;
    logic [31:0] i_pc, i_sig_data;
    logic [2:0]  o_state;
    logic        o_done, o_pass;
    logic [1:0]  o_cause;
    logic [31:0] o_cycle_cnt, o_insn_cnt, o_halt_pc, o_sig;

    pc_run_monitor dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_pc(i_pc),
        .i_insn_vld(i_insn_vld), .i_sig_vld(i_sig_vld), .i_sig_data(i_sig_data),
        .o_state(o_state), .o_done(o_done), .o_pass(o_pass), .o_cause(o_cause),
        .o_cycle_cnt(o_cycle_cnt), .o_insn_cnt(o_insn_cnt), .o_halt_pc(o_halt_pc),
        .o_sig(o_sig));

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model
    int          m_state, m_idle;
    logic        m_done, m_pass;
    logic [1:0]  m_cause;
    longint      m_cyc, m_insn;
    logic [31:0] m_hpc, m_sig;
    logic [31:0] hist[$];

    typedef struct {
        int          rep_at, sig_at;
        logic [31:0] sig_data;
        int          stall_at, stall_end;
        logic        exp_pass;
        logic [1:0]  exp_cause;
        int          exp_cyc, exp_insn;
        logic [31:0] exp_pc, exp_sig;
    } scen_t;
    scen_t tbl[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_idle = 0; m_done = 0; m_pass = 0; m_cause = 0;
        m_cyc = 0; m_insn = 0; m_hpc = 0; m_sig = 0;
        hist.delete();
    endtask

    task automatic finish_run(input logic p, input logic [1:0] c);
        m_state = p ? 2 : 3;
        m_done  = 1'b1;
        m_pass  = p;
        m_cause = c;
        m_hpc   = i_pc;
    endtask

    task automatic model_step();
        bit halt;
        halt = 0;
        if (m_state == 0) begin
            if (i_enable) m_state = 1;
        end else if (m_state == 1 && i_enable) begin
            m_cyc++;
            if (i_insn_vld) begin
                m_insn++;
                m_idle = 0;
                hist.push_back(i_pc);
                if (hist.size() > HR) void'(hist.pop_front());
                if (hist.size() == HR) begin
                    halt = 1;
                    foreach (hist[j]) if (hist[j] != i_pc) halt = 0;
                end
            end else begin
                m_idle++;
            end
            if (i_sig_vld) begin
                m_sig = i_sig_data;
                finish_run(i_sig_data == 32'h1, 2'd0);
            end else if (halt)         finish_run(1'b1, 2'd1);
            else if (m_idle >= SL)     finish_run(1'b0, 2'd2);
            else if (m_cyc >= MC)      finish_run(1'b0, 2'd3);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},   o_state,     m_state[2:0]);
        chk({tag, ".done"},    o_done,      m_done);
        chk({tag, ".pass"},    o_pass,      m_pass);
        chk({tag, ".cause"},   o_cause,     m_cause);
        chk({tag, ".cyc"},     o_cycle_cnt, m_cyc[31:0]);
        chk({tag, ".insn"},    o_insn_cnt,  m_insn[31:0]);
        chk({tag, ".halt_pc"}, o_halt_pc,   m_hpc);
        chk({tag, ".sig"},     o_sig,       m_sig);
    endtask

    task automatic tick(input string tag);
        @(posedge i_clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        i_reset = 1; i_enable = 0; i_insn_vld = 0; i_sig_vld = 0;
        i_pc = 0; i_sig_data = 0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge i_clk);
        i_reset = 0;
        #1;
    endtask

    task automatic run_scen(input scen_t s, input int id);
        string tag;
        tag = $sformatf("scen%0d", id);
        do_reset();
        i_enable = 1;
        tick(tag);
        for (int k = 1; k <= 9000 && !o_done; k++) begin
            i_pc       = (s.rep_at != 0 && k >= s.rep_at) ? s.rep_at * 4 : k * 4;
            i_insn_vld = !(s.stall_at != 0 && k >= s.stall_at && (s.stall_end == 0 || k < s.stall_end));
            i_sig_vld  = (k == s.sig_at);
            i_sig_data = s.sig_data;
            tick(tag);
        end
        // terminal state must ignore further activity
        for (int k = 0; k < 3; k++) begin
            i_pc = $urandom; i_insn_vld = 1; i_sig_vld = 1; i_sig_data = 32'h1;
            tick({tag, ".hold"});
        end
        i_sig_vld = 0;
        chk({tag, ".fin_done"},  o_done,      1'b1);
        chk({tag, ".fin_pass"},  o_pass,      s.exp_pass);
        chk({tag, ".fin_cause"}, o_cause,     s.exp_cause);
        chk({tag, ".fin_cyc"},   o_cycle_cnt, s.exp_cyc);
        chk({tag, ".fin_insn"},  o_insn_cnt,  s.exp_insn);
        chk({tag, ".fin_pc"},    o_halt_pc,   s.exp_pc);
        chk({tag, ".fin_sig"},   o_sig,       s.exp_sig);
    endtask

    initial begin
        //          rep sig data        st    end  pass cause cyc   insn  pc         sig
        tbl[0] = '{10, 0,  32'h0,      0,    0,   1'b1, 2'd1, 13,   13,   32'h28,    32'h0};
        tbl[1] = '{0,  20, 32'h1,      0,    0,   1'b1, 2'd0, 20,   20,   32'h50,    32'h1};
        tbl[2] = '{0,  20, 32'hDEAD,   0,    0,   1'b0, 2'd0, 20,   20,   32'h50,    32'hDEAD};
        tbl[3] = '{0,  0,  32'h0,      11,   0,   1'b0, 2'd2, 74,   10,   32'h128,   32'h0};
        tbl[4] = '{10, 13, 32'h1,      0,    0,   1'b1, 2'd0, 13,   13,   32'h28,    32'h1};
        tbl[5] = '{0,  0,  32'h0,      0,    0,   1'b0, 2'd3, 8000, 8000, 32'd32000, 32'h0};
        tbl[6] = '{0,  0,  32'h0,      7937, 0,   1'b0, 2'd2, 8000, 7936, 32'd32000, 32'h0};
        tbl[7] = '{0,  80, 32'h1,      11,   74,  1'b1, 2'd0, 80,   17,   32'd320,   32'h1};

        foreach (tbl[i]) run_scen(tbl[i], i);

        // asynchronous reset between edges
        do_reset();
        i_enable = 1;
        tick("arst");
        for (int k = 1; k <= 6; k++) begin
            i_pc = k * 4; i_insn_vld = 1;
            tick("arst");
        end
        #3;
        i_reset = 1;
        model_reset();
        #1;
        check_all("arst_now");
        chk("arst_cyc_zero", o_cycle_cnt, 32'h0);
        @(negedge i_clk);
        i_reset = 0;

        // enable low freezes everything, no stall build-up
        do_reset();
        i_enable = 1;
        tick("freeze");
        for (int k = 1; k <= 10; k++) begin
            i_pc = k * 4; i_insn_vld = 1;
            tick("freeze");
        end
        i_enable = 0; i_insn_vld = 0;
        for (int k = 0; k < 30; k++) tick("freeze_off");
        chk("freeze_cyc", o_cycle_cnt, 32'd10);
        chk("freeze_state", o_state, 3'd1);
        i_enable = 1;
        for (int k = 11; k <= 15; k++) begin
            i_pc = k * 4; i_insn_vld = 1;
            tick("freeze_on");
        end
        chk("freeze_resume_cyc", o_cycle_cnt, 32'd15);
        chk("freeze_resume_done", o_done, 1'b0);

        // random traffic with occasional mid-run resets
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 199) == 0) do_reset();
                i_enable   = ($urandom_range(0, 9) < 8);
                i_insn_vld = ($urandom_range(0, 9) < 7);
                i_pc       = ($urandom_range(0, 3) < 3) ? 32'($urandom_range(0, 2) * 4) : $urandom;
                i_sig_vld  = ($urandom_range(0, 49) == 0);
                i_sig_data = ($urandom_range(0, 1) == 1) ? 32'h1 : $urandom;
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pc_run_monitor.md
Name: pc_run_monitor

Overview:
- Parametrised run-control monitor that sits beside the single-cycle core, in simulation harnesses and on the FPGA top.
- Replaces fixed "run N cycles then stop" control with observed termination. It watches the core's debug PC, instruction-valid strobe and a signature write port.
- It decides when a program has finished: self-loop halt, signature write, instruction stall, or cycle timeout.
- It counts cycles and retired instructions, and reports a sticky pass/fail verdict plus the cause.

Parameters:
- PC_W, 32, width of the monitored PC.
- CNT_W, 32, width of the cycle and instruction counters.
- MAX_CYCLES, 8000, cycle budget before a timeout verdict; must be ≥1.
- HALT_REPEAT, 4, consecutive valid retirements at an identical PC that count as a halt; must be ≥2.
- STALL_LIMIT, 64, consecutive cycles without o_insn_vld that count as a stall; must be ≥1.
- PASS_CODE, 32'h0000_0001, signature value that means pass.

Ports:
- i_clk, in, 1, clock.
- i_reset, in, 1, asynchronous active-high reset.
- i_enable, in, 1, run gate; counters and FSM advance only while high.
- i_pc, in, PC_W, core debug PC (o_pc_debug).
- i_insn_vld, in, 1, core instruction-valid (o_insn_vld).
- i_sig_vld, in, 1, one-cycle strobe: the program wrote its signature.
- i_sig_data, in, 32, signature value.
- o_state, out, 3, FSM state encoding.
- o_done, out, 1, sticky: a verdict has been reached.
- o_pass, out, 1, sticky: the verdict is pass; valid only while o_done=1.
- o_cause, out, 2, termination cause: 0=SIG, 1=HALT, 2=STALL, 3=TIMEOUT.
- o_cycle_cnt, out, CNT_W, enabled cycles spent in RUN.
- o_insn_cnt, out, CNT_W, valid retirements seen in RUN.
- o_halt_pc, out, PC_W, PC captured at termination.
- o_sig, out, 32, last captured signature.

Behaviour:
- Reset (async, i_reset=1): state=IDLE; every output 0; internal repeat/stall counters and last-PC register 0.
- States: IDLE=0, RUN=1, PASS=2, FAIL=3. PASS and FAIL are terminal; only reset leaves them.
- IDLE -> RUN on the first clock edge with i_enable=1. No counting happens on that edge.
- RUN, on each edge with i_enable=1:
  - cycle_cnt += 1.
  - If i_insn_vld: insn_cnt += 1; stall counter cleared. If i_pc equals last_pc, the repeat counter increments; otherwise it loads 1. last_pc <= i_pc.
  - If !i_insn_vld: stall counter += 1; repeat counter held.
- RUN with i_enable=0: everything frozen, with no stall accumulation.
- Termination checks are evaluated from the values updated on the current edge. Priority when several hold on the same edge: SIG > HALT > STALL > TIMEOUT.
  - SIG: i_sig_vld=1. o_sig <= i_sig_data. Go to PASS if i_sig_data==PASS_CODE, else FAIL.
  - HALT: repeat counter reaches HALT_REPEAT. Go to PASS (a jal x0,0 tail loop is a legal end).
  - STALL: stall counter reaches STALL_LIMIT. Go to FAIL.
  - TIMEOUT: cycle_cnt reaches MAX_CYCLES. Go to FAIL.
- On entering PASS/FAIL, all of the following register on the same edge: o_done=1, o_pass=(state==PASS), o_cause, o_halt_pc=i_pc. The counts include the terminating cycle.
- Latency: a verdict is visible one cycle after the triggering edge's inputs, i.e. registered outputs with no combinational path from inputs to outputs.
- i_sig_vld outside RUN is ignored; o_sig is not updated.
- Counters saturate at all-ones. They never wrap.
- An i_pc change while i_insn_vld=0 has no effect on halt detection.
- Reset asserted mid-RUN or in a terminal state returns immediately (asynchronously) to the IDLE/all-zero values.
- Outputs stay stable in terminal states regardless of inputs.

Decomposition:
- Package pc_run_monitor_pkg holds:
  - the state enum: IDLE, RUN, PASS, FAIL;
  - the cause enum: SIG, HALT, STALL, TIMEOUT;
  - the default PASS_CODE constant.
- One natural sub-module, sat_counter (parametrised width, inc, clr, saturating). It is instantiated for cycle, insn, stall and repeat counts.
- FSM and capture registers live in the top.

Test Plan:
- Reset then enable; drive distinct PCs with vld every cycle; at cycle 10, PC 0x28 repeats with vld for 4 cycles -> PASS, cause=HALT, o_halt_pc=0x28, o_insn_cnt=13, o_done=1.
- Distinct PCs; i_sig_vld with data 0x1 at cycle 20 -> PASS, cause=SIG, o_sig=0x1. Same run with data 0xDEAD -> FAIL, cause=SIG, o_sig=0xDEAD.
- Distinct PCs then hold i_insn_vld=0 for 64 cycles -> FAIL, cause=STALL. Also: 63 idle cycles then one valid does not terminate.
- MAX_CYCLES=8000, never repeating PCs, no signature -> FAIL, cause=TIMEOUT, o_cycle_cnt=8000.
- Same edge carries i_sig_vld=1 (data 0x1) and the 4th repeat -> cause=SIG, not HALT. Same edge carries the 64th stall cycle and cycle 8000 -> cause=STALL.
- Assert i_reset asynchronously mid-RUN (between edges) -> all outputs 0 immediately. Toggle i_enable low for 30 cycles in RUN -> counts frozen, no stall verdict.
